// File: rtl/tdm_demux4.sv
// -----------------------------------------------------------------------------
// tdm_demux4 -- four-channel time-division demultiplexer
//
// A serial stream of channel words arrives one time slot per valid cycle.
// Slot 0 of each frame is marked by in_sync. The block locks onto the first
// sync it sees, then steers each valid word into the channel register named
// by a free-running 2-bit slot counter. Each capture is reported one cycle
// later by a one-hot out_strobe pulse. frame_done pulses together with the
// slot-3 strobe.
//
// Optional feature (compile-time macro TDM_DEMUX_SYNC_CHECK_EN):
//   When this macro is defined, a sync that arrives at a slot other than 0
//   while locked sets the sticky sync_err flag. The block also realigns:
//   that word is stored as slot 0, and the next word goes to slot 1.
//   When the macro is undefined, in_sync is ignored while locked and
//   sync_err is tied to 0.
//
// Parameters
//   WIDTH       data width of in_data and of each channel output
//
// Ports
//   clk         single clock; all state updates on its rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    in_data carries one time slot this cycle
//   in_sync     current valid word is slot 0 (qualified by in_valid)
//   in_data     serialized channel word
//   out_data0-3 last captured word of channels 0..3
//   out_strobe  one-hot, one-cycle pulse naming the channel just updated
//   frame_done  one-cycle pulse when slot 3 is captured
//   locked      high while the framer is in LOCKED
//   sync_err    sticky misaligned-sync flag (cleared only by reset)
// -----------------------------------------------------------------------------
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [3:0]       out_strobe,
  output logic             frame_done,
  output logic             locked,
  output logic             sync_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] slot, slot_nxt;

  // Decoded capture request for the current input word.
  logic       cap_en;
  logic [1:0] cap_idx;
  logic [3:0] strobe_nxt;
  logic       frame_done_nxt;

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  logic       err_set;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / capture decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    slot_nxt  = slot;
    cap_en    = 1'b0;
    cap_idx   = slot;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    err_set   = 1'b0;
`endif

    unique case (state)
      HUNT: begin
        // Words without sync are dropped while hunting.
        if (in_valid && in_sync) begin
          cap_en    = 1'b1;
          cap_idx   = 2'd0;
          slot_nxt  = 2'd1;
          state_nxt = LOCKED;
        end
      end

      LOCKED: begin
        if (in_valid) begin
          cap_en = 1'b1;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
          // A sync that arrives at a slot other than 0 means we lost frame
          // alignment. Treat this word as slot 0 and restart the count.
          if (in_sync && (slot != 2'd0)) begin
            err_set  = 1'b1;
            cap_idx  = 2'd0;
            slot_nxt = 2'd1;
          end else begin
            cap_idx  = slot;
            slot_nxt = slot + 2'd1;
          end
`else
          cap_idx  = slot;
          slot_nxt = slot + 2'd1;
`endif
        end
      end

      default: begin
        state_nxt = HUNT;
        slot_nxt  = 2'd0;
      end
    endcase

    strobe_nxt     = cap_en ? (4'b0001 << cap_idx) : 4'b0000;
    frame_done_nxt = cap_en && (cap_idx == 2'd3);
  end

  // ---------------------------------------------------------------------------
  // Stage boundary: control and channel registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      slot       <= 2'd0;
      out_strobe <= 4'b0000;
      frame_done <= 1'b0;
      out_data0  <= '0;
      out_data1  <= '0;
      out_data2  <= '0;
      out_data3  <= '0;
    end else begin
      state      <= state_nxt;
      slot       <= slot_nxt;
      out_strobe <= strobe_nxt;
      frame_done <= frame_done_nxt;
      if (strobe_nxt[0]) out_data0 <= in_data;
      if (strobe_nxt[1]) out_data1 <= in_data;
      if (strobe_nxt[2]) out_data2 <= in_data;
      if (strobe_nxt[3]) out_data3 <= in_data;
    end
  end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else if (err_set) begin
      sync_err <= 1'b1;
    end
  end
`else
  assign sync_err = 1'b0;
`endif

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux4 -- self-checking bench for tdm_demux4 (WIDTH = 4).
// The expected-value table follows TDM_DEMUX_SYNC_CHECK_EN, the same macro
// the design uses.
// -----------------------------------------------------------------------------
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_sync;
  logic [3:0] in_data;
  logic [3:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_strobe;
  logic       frame_done, locked, sync_err;

  int n_chk  = 0;
  int n_fail = 0;

  tdm_demux4 #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sync    (in_sync),
    .in_data    (in_data),
    .out_data0  (out_data0),
    .out_data1  (out_data1),
    .out_data2  (out_data2),
    .out_data3  (out_data3),
    .out_strobe (out_strobe),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       s;
    logic [3:0] d;
    logic [3:0] stb;
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       fd;
    logic       lk;
    logic       err;
  } vec_t;

  vec_t tbl[17];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic v, input logic s, input logic [3:0] d,
                              input logic [3:0] stb, input logic [3:0] d0,
                              input logic [3:0] d1, input logic [3:0] d2,
                              input logic [3:0] d3, input logic fd,
                              input logic lk, input logic err);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.stb = stb;
    r.d0 = d0; r.d1 = d1; r.d2 = d2; r.d3 = d3;
    r.fd = fd; r.lk = lk; r.err = err;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input vec_t e);
    chk({tag, ".d0"},  {28'd0, out_data0},  {28'd0, e.d0});
    chk({tag, ".d1"},  {28'd0, out_data1},  {28'd0, e.d1});
    chk({tag, ".d2"},  {28'd0, out_data2},  {28'd0, e.d2});
    chk({tag, ".d3"},  {28'd0, out_data3},  {28'd0, e.d3});
    chk({tag, ".stb"}, {28'd0, out_strobe}, {28'd0, e.stb});
    chk({tag, ".fd"},  {31'd0, frame_done}, {31'd0, e.fd});
    chk({tag, ".lk"},  {31'd0, locked},     {31'd0, e.lk});
    chk({tag, ".err"}, {31'd0, sync_err},   {31'd0, e.err});
  endtask

  // Drive one word on the falling edge, then check the registered result
  // just after the next rising edge.
  task automatic run_vec(input int idx);
    vec_t e;
    @(negedge clk);
    in_valid = tbl[idx].v;
    in_sync  = tbl[idx].s;
    in_data  = tbl[idx].d;
    exp_q.push_back(tbl[idx]);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    cmp_all($sformatf("vec%0d", idx), e);
  endtask

  initial begin
    vec_t zero_v;
    zero_v = mk(0, 0, 4'h0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);

    //          v  s  d     stb      d0    d1    d2    d3   fd lk err
    tbl[0]  = mk(1, 0, 4'hA, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 4'hB, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 4'h1, 4'b0001, 4'h1, 4'h0, 4'h0, 4'h0, 0, 1, 0);
    tbl[3]  = mk(1, 0, 4'h2, 4'b0010, 4'h1, 4'h2, 4'h0, 4'h0, 0, 1, 0);
    tbl[4]  = mk(1, 0, 4'h3, 4'b0100, 4'h1, 4'h2, 4'h3, 4'h0, 0, 1, 0);
    tbl[5]  = mk(1, 0, 4'h4, 4'b1000, 4'h1, 4'h2, 4'h3, 4'h4, 1, 1, 0);
    tbl[6]  = mk(1, 1, 4'h9, 4'b0001, 4'h9, 4'h2, 4'h3, 4'h4, 0, 1, 0);
    tbl[7]  = mk(0, 1, 4'h5, 4'b0000, 4'h9, 4'h2, 4'h3, 4'h4, 0, 1, 0);
    tbl[8]  = mk(0, 0, 4'h6, 4'b0000, 4'h9, 4'h2, 4'h3, 4'h4, 0, 1, 0);
    tbl[9]  = mk(1, 0, 4'hA, 4'b0010, 4'h9, 4'hA, 4'h3, 4'h4, 0, 1, 0);
    tbl[10] = mk(0, 0, 4'hF, 4'b0000, 4'h9, 4'hA, 4'h3, 4'h4, 0, 1, 0);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    tbl[11] = mk(1, 1, 4'h7, 4'b0001, 4'h7, 4'hA, 4'h3, 4'h4, 0, 1, 1);
    tbl[12] = mk(1, 0, 4'h8, 4'b0010, 4'h7, 4'h8, 4'h3, 4'h4, 0, 1, 1);
    tbl[13] = mk(1, 0, 4'hC, 4'b0100, 4'h7, 4'h8, 4'hC, 4'h4, 0, 1, 1);
`else
    tbl[11] = mk(1, 1, 4'h7, 4'b0100, 4'h9, 4'hA, 4'h7, 4'h4, 0, 1, 0);
    tbl[12] = mk(1, 0, 4'h8, 4'b1000, 4'h9, 4'hA, 4'h7, 4'h8, 1, 1, 0);
    tbl[13] = mk(1, 0, 4'hC, 4'b0001, 4'hC, 4'hA, 4'h7, 4'h8, 0, 1, 0);
`endif
    // After the mid-frame reset: a non-sync word is dropped, then relock.
    tbl[14] = mk(1, 0, 4'h5, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    tbl[15] = mk(1, 1, 4'h6, 4'b0001, 4'h6, 4'h0, 4'h0, 4'h0, 0, 1, 0);
    tbl[16] = mk(1, 0, 4'h2, 4'b0010, 4'h6, 4'h2, 4'h0, 4'h0, 0, 1, 0);

    // Reset state, with busy inputs present while reset is held.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_sync  = 1'b1;
    in_data  = 4'hF;
    #1;
    cmp_all("reset", zero_v);
    repeat (2) @(posedge clk);
    #1;
    cmp_all("reset_held", zero_v);
    @(negedge clk);
    in_valid = 1'b0;
    in_sync  = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i <= 13; i++) run_vec(i);

    // Assert reset between clock edges while the frame is partly filled.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    cmp_all("midrst", zero_v);
    @(posedge clk);
    #1;
    cmp_all("midrst_held", zero_v);
    @(negedge clk);
    in_valid = 1'b0;
    in_sync  = 1'b0;
    rst_n    = 1'b1;

    for (int i = 14; i <= 16; i++) run_vec(i);

    // A strobe lasts one cycle: with no more input it must drop.
    @(negedge clk);
    in_valid = 1'b0;
    in_sync  = 1'b0;
    @(posedge clk);
    #1;
    chk("strobe_clear", {28'd0, out_strobe}, 32'd0);
    chk("hold_d1",      {28'd0, out_data1},  32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width of the input word and of each channel output.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: in_data carries one time slot this cycle.
REQ-005 The block SHALL have port in_sync, input, 1 bit: the current valid word is slot 0 of a frame; it is qualified by in_valid.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the serialized channel word.
REQ-007 The block SHALL have ports out_data0, out_data1, out_data2 and out_data3, output, WIDTH bits each: the last captured word of channels 0-3.
REQ-008 The block SHALL have port out_strobe, output, 4 bits: a one-hot, one-cycle pulse marking which channel register updated.
REQ-009 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse when slot 3 is captured.
REQ-010 The block SHALL have port locked, output, 1 bit: high while in state LOCKED.
REQ-011 The block SHALL have port sync_err, output, 1 bit: a sticky misaligned-sync flag (see Configuration).

Function
REQ-012 The block SHALL implement a two-state FSM with states HUNT and LOCKED, plus a 2-bit slot counter.
REQ-013 In HUNT, words with in_valid=1 and in_sync=0 SHALL be discarded, with no register or strobe change.
REQ-014 In HUNT, in_valid=1 with in_sync=1 SHALL capture in_data into out_data0, set slot to 1 and enter LOCKED.
REQ-015 In LOCKED, each in_valid=1 word SHALL be captured into out_data[slot], and slot SHALL increment modulo 4 (3 wraps to 0).
REQ-016 A cycle with in_valid=0 SHALL change no state; out_strobe and frame_done SHALL be 0 on the next cycle.
REQ-017 The capture latency SHALL be 1 cycle: when a word is sampled at edge N, out_dataK and out_strobe[K] SHALL be visible after edge N; the strobe lasts exactly one cycle.
REQ-018 frame_done SHALL assert in the same cycle as out_strobe[3], and only then.
REQ-019 Channel registers not addressed SHALL hold their value; back-to-back valid words SHALL be accepted every cycle with no bubbles.
REQ-020 in_sync SHALL be ignored when in_valid=0.
REQ-021 In LOCKED, in_sync=1 arriving at slot 0 is correct alignment and SHALL be processed as a normal capture.

Reset
REQ-022 rst_n low SHALL immediately force: state HUNT; slot 0; out_data0-3 all zeros; out_strobe 4'b0000; frame_done 0; locked 0; sync_err 0.
REQ-023 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL hunt for a new in_sync.
REQ-024 Reset release SHALL take effect at the first rising clk edge after rst_n goes high.

Configuration
REQ-025 The macro TDM_DEMUX_SYNC_CHECK_EN SHALL control sync checking.
REQ-026 With TDM_DEMUX_SYNC_CHECK_EN defined, in LOCKED, in_valid=1 with in_sync=1 at slot other than 0 SHALL set sync_err, which stays set until reset.
REQ-027 In that same event the block SHALL resynchronise: the word is captured into out_data0 with out_strobe=0001, and slot is set to 1.
REQ-028 Without TDM_DEMUX_SYNC_CHECK_EN, in_sync SHALL be ignored in LOCKED, the word SHALL be captured by the slot counter, and sync_err SHALL be tied to 0.

Verification
REQ-029 The bench SHALL cover: reset, then valid words A,B with sync=0 -> all outputs stay 0 and locked=0.
REQ-030 The bench SHALL cover: WIDTH=4, sync on 0x1, then 0x2,0x3,0x4 back-to-back -> out_data0..3 = 1,2,3,4; strobes 0001,0010,0100,1000 on successive cycles; frame_done coincides with 1000; locked=1.
REQ-031 The bench SHALL cover: a second frame 0x9,0xA with in_valid gaps between them -> only out_data0/1 change, to 9/A; out_data2/3 hold 3/4; no strobe during gaps.
REQ-032 The bench SHALL cover: with the macro defined, sync asserted at slot 2 with 0x7 -> sync_err=1 (sticky), out_data0=7, strobe 0001, and the next word goes to out_data1.
REQ-033 The bench SHALL cover: the same stimulus without the macro -> 0x7 lands in out_data2, strobe 0100, sync_err=0.
REQ-034 The bench SHALL cover: rst_n pulsed low mid-frame between clock edges -> outputs zero immediately, locked=0, and a new sync is required.
